// File: rtl/sdram_startup_sequencer.sv
// Power-up sequencer for NUM_CH SDRAM channels, handled strictly one after another:
// hold init_n low, wait for the controller's acknowledge (with timeout and retry), settle, then flag ready.
module sdram_startup_sequencer #(
  parameter real CLK            = 111857000.0,
  parameter int  NUM_CH         = 2,
  parameter real PU_SEC         = 0.201,
  parameter int  SETTLE_CYCLES  = 64,
  parameter int  TIMEOUT_CYCLES = 4096,
  parameter int  MAX_RETRY      = 2,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk8M,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] init_done,
  output logic [NUM_CH-1:0] sdram_init_n,
  output logic [NUM_CH-1:0] sdram_ready,
  output logic              all_ready,
  output logic              error,
  output logic [CH_W-1:0]   fail_ch
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int PU_CYCLES = int'($ceil(PU_SEC * CLK));
  localparam int CNT_W     = $clog2(max2(max2(PU_CYCLES, SETTLE_CYCLES), TIMEOUT_CYCLES)) + 1;
  localparam int RTY_W     = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PU_LAST  = CNT_W'(PU_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W-1:0]   CH_ZERO  = {CH_W{1'b0}};
  localparam logic [CH_W-1:0]   CH_ONE   = CH_W'(1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [RTY_W-1:0]  RTY_ZERO = {RTY_W{1'b0}};
  localparam logic [RTY_W-1:0]  RTY_ONE  = RTY_W'(1);
  localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [NUM_CH-1:0] CH_BIT0  = NUM_CH'(1);
  localparam logic [NUM_CH-1:0] ALL_ONES = {NUM_CH{1'b1}};
  localparam logic [NUM_CH-1:0] ALL_ZERO = {NUM_CH{1'b0}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POWERUP   = 3'd1,
    INIT_WAIT = 3'd2,
    SETTLE    = 3'd3,
    DONE      = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [CH_W-1:0]    ch_r, ch_s;
  logic [RTY_W-1:0]   retry_r, retry_s;
  logic               settle_hit_s;
  logic [NUM_CH-1:0]  init_n_s, ready_s;
  logic               all_ready_s, error_s;
  logic [CH_W-1:0]    fail_ch_s;

  // Next-state, counters and next output values; start low beats every other transition.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ch_s    = ch_r;
    retry_s = retry_r;
    if (!start) begin
      state_s = IDLE;
      cnt_s   = CNT_ZERO;
      ch_s    = CH_ZERO;
      retry_s = RTY_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = POWERUP;
          cnt_s   = CNT_ZERO;
          ch_s    = CH_ZERO;
          retry_s = RTY_ZERO;
        end
        POWERUP: begin
          if (cnt_r == PU_LAST) begin
            state_s = INIT_WAIT;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        INIT_WAIT: begin
          // an acknowledge arriving on the timeout cycle still wins
          if (init_done[ch_r]) begin
            state_s = SETTLE;
            cnt_s   = CNT_ZERO;
          end else if (cnt_r == TO_LAST) begin
            cnt_s = CNT_ZERO;
            if (retry_r < RTY_MAX) begin
              retry_s = retry_r + RTY_ONE;
              state_s = POWERUP;
            end else begin
              state_s = FAIL;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        SETTLE: begin
          if (cnt_r == SET_LAST) begin
            cnt_s = CNT_ZERO;
            if (ch_r == CH_LAST) begin
              state_s = DONE;
            end else begin
              ch_s    = ch_r + CH_ONE;
              retry_s = RTY_ZERO;
              state_s = POWERUP;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        DONE:    state_s = DONE;
        FAIL:    state_s = FAIL;
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          ch_s    = CH_ZERO;
          retry_s = RTY_ZERO;
        end
      endcase
    end

    // outputs are derived from the next state so they appear on the same edge as the transition
    settle_hit_s = (state_r == SETTLE) && (cnt_r == SET_LAST) && start;
    init_n_s     = (state_s == POWERUP) ? ~(CH_BIT0 << ch_s) : ALL_ONES;
    ready_s      = (state_s == IDLE) ? ALL_ZERO :
                   (settle_hit_s ? (sdram_ready | (CH_BIT0 << ch_r)) : sdram_ready);
    all_ready_s  = (state_s == DONE);
    error_s      = (state_s == FAIL);
    fail_ch_s    = (state_s == FAIL) ? ch_s : CH_ZERO;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk8M or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      ch_r         <= CH_ZERO;
      retry_r      <= RTY_ZERO;
      sdram_init_n <= ALL_ONES;
      sdram_ready  <= ALL_ZERO;
      all_ready    <= 1'b0;
      error        <= 1'b0;
      fail_ch      <= CH_ZERO;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      ch_r         <= ch_s;
      retry_r      <= retry_s;
      sdram_init_n <= init_n_s;
      sdram_ready  <= ready_s;
      all_ready    <= all_ready_s;
      error        <= error_s;
      fail_ch      <= fail_ch_s;
    end
  end

endmodule

// File: tb/tb_sdram_startup_sequencer.sv
// Scoreboard bench: a timeline model predicts every output change; a negedge monitor pops and compares.
module tb_sdram_startup_sequencer;

  localparam int N  = 2;
  localparam int MR = 1;
  localparam int PU = 10;
  localparam int S  = 4;
  localparam int TO = 8;

  typedef struct {
    int         t;
    logic [6:0] v;
  } ev_t;

  logic       clk8M = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] init_done;
  logic [1:0] sdram_init_n;
  logic [1:0] sdram_ready;
  logic       all_ready;
  logic       error;
  logic [0:0] fail_ch;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  ev_t  exp_q[$];
  logic [6:0] mon_last;
  int   ack_k [N][MR+1];
  int   att [N];
  int   w [N];

  sdram_startup_sequencer #(
    .CLK(1000.0), .NUM_CH(2), .PU_SEC(0.01), .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(8), .MAX_RETRY(1)
  ) dut (
    .clk8M(clk8M), .rst(rst), .start(start), .init_done(init_done),
    .sdram_init_n(sdram_init_n), .sdram_ready(sdram_ready),
    .all_ready(all_ready), .error(error), .fail_ch(fail_ch)
  );

  initial forever #5 clk8M = ~clk8M;

  always @(posedge clk8M) cyc <= cyc + 1;

  function automatic logic [6:0] mk(input logic [1:0] n, input logic [1:0] r,
                                    input logic a, input logic e, input logic f);
    return {n, r, a, e, f};
  endfunction

  localparam logic [6:0] RESET_V = 7'b11_00_0_0_0;

  // Record that outputs must read v from edge t on; same-edge updates collapse into one change.
  function automatic void expect_at(input int t, input logic [6:0] v);
    logic [6:0] base;
    if (exp_q.size() > 0 && exp_q[$].t == t) void'(exp_q.pop_back());
    base = (exp_q.size() > 0) ? exp_q[$].v : mon_last;
    if (v != base) exp_q.push_back('{t: t, v: v});
  endfunction

  function automatic void abort_at(input int a);
    while (exp_q.size() > 0 && exp_q[$].t >= a) void'(exp_q.pop_back());
    expect_at(a, RESET_V);
  endfunction

  // Timeline of a full run whose start is first sampled at edge e; returns the DONE/FAIL edge.
  function automatic int plan_seq(input int e);
    int t, a;
    bit acked;
    logic [1:0] rdy, low;
    t = e;
    rdy = 2'b00;
    for (int c = 0; c < N; c++) begin
      acked = 1'b0;
      a = 0;
      while (!acked) begin
        low = 2'b11;
        low[c] = 1'b0;
        expect_at(t, mk(low, rdy, 1'b0, 1'b0, 1'b0));
        t += PU;
        expect_at(t, mk(2'b11, rdy, 1'b0, 1'b0, 1'b0));
        if (ack_k[c][a] >= 1 && ack_k[c][a] <= TO) begin
          t += ack_k[c][a] + S;
          rdy[c] = 1'b1;
          expect_at(t, mk(2'b11, rdy, (c == N-1), 1'b0, 1'b0));
          acked = 1'b1;
        end else begin
          t += TO;
          if (a == MR) begin
            expect_at(t, mk(2'b11, rdy, 1'b0, 1'b1, 1'(c)));
            return t;
          end
          a++;
        end
      end
    end
    return t;
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk8M);
      #1;
    end
  endtask

  task automatic ctl_reset();
    for (int c = 0; c < N; c++) begin
      att[c] = -1;
      w[c] = 0;
    end
    init_done = 2'b00;
  endtask

  task automatic check_drained(input string name);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d expected changes never seen (first t=%0d v=%b), required 0",
               name, exp_q.size(), exp_q[0].t, exp_q[0].v);
      exp_q.delete();
    end
  endtask

  task automatic check_now(input string name, input logic [6:0] want);
    logic [6:0] got;
    got = {sdram_init_n, sdram_ready, all_ready, error, fail_ch};
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic scenario(input string name, input int k0a, input int k0b,
                          input int k1a, input int k1b, input int abort_off);
    int e, fin, a;
    ack_k[0][0] = k0a; ack_k[0][1] = k0b;
    ack_k[1][0] = k1a; ack_k[1][1] = k1b;
    ctl_reset();
    e = cyc + 3;
    fin = plan_seq(e);
    a = (abort_off > 0 && e + abort_off <= fin) ? e + abort_off : fin + 2;
    abort_at(a);
    wait_until(e - 1);
    start = 1'b1;
    wait_until(a - 1);
    start = 1'b0;
    wait_until(a + 3);
    check_drained(name);
  endtask

  // Controller model: raise init_done[c] k edges after init_n[c] rises (k = 0 means never ack).
  initial begin
    logic [1:0] prev_n;
    prev_n = 2'b11;
    forever begin
      @(negedge clk8M);
      for (int c = 0; c < N; c++) begin
        if (prev_n[c] && !sdram_init_n[c]) begin
          att[c]++;
          w[c] = 0;
          init_done[c] = 1'b0;
        end else if (!prev_n[c] && sdram_init_n[c]) begin
          w[c] = 1;
        end else if (w[c] > 0) begin
          w[c]++;
        end
        if (w[c] > 0 && att[c] >= 0 && att[c] <= MR && ack_k[c][att[c]] != 0 &&
            w[c] >= ack_k[c][att[c]])
          init_done[c] = 1'b1;
      end
      prev_n = sdram_init_n;
    end
  end

  // Monitor: every change of the output vector must be the next expected change, at the expected edge.
  initial begin
    logic [6:0] obs, obs_prev;
    ev_t ev;
    mon_last = RESET_V;
    obs_prev = RESET_V;
    forever begin
      @(negedge clk8M);
      obs = {sdram_init_n, sdram_ready, all_ready, error, fail_ch};
      if (obs !== obs_prev) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_change: at t=%0d got %b, required no change from %b", cyc, obs, obs_prev);
        end else begin
          ev = exp_q.pop_front();
          mon_last = ev.v;
          if (ev.t != cyc || ev.v !== obs) begin
            mismatched++;
            $display("FAIL output_change: got t=%0d v=%b, required t=%0d v=%b", cyc, obs, ev.t, ev.v);
          end
        end
        obs_prev = obs;
      end
    end
  end

  initial begin
    int e, fin, r, e2, a, ab;
    int k [4];
    rst = 1'b0;
    start = 1'b0;
    ctl_reset();
    for (int c = 0; c < N; c++) for (int j = 0; j <= MR; j++) ack_k[c][j] = 0;
    #2 rst = 1'b1;
    wait_until(3);
    check_now("reset_state", RESET_V);
    rst = 1'b0;
    wait_until(6);
    check_now("idle_without_start", RESET_V);

    scenario("nominal",        2, 2, 2, 2, 0);
    scenario("single_timeout", 2, 2, 0, 2, 0);
    scenario("exhausted",      2, 2, 0, 0, 0);
    scenario("abort_powerup",  2, 2, 2, 2, 5);
    scenario("restart_full",   2, 2, 2, 2, 0);
    scenario("ack_collision",  TO, 2, 2, 2, 0);

    // asynchronous reset in the middle of channel 1 settle, start held high throughout
    ack_k[0][0] = 2; ack_k[0][1] = 2; ack_k[1][0] = 2; ack_k[1][1] = 2;
    ctl_reset();
    e = cyc + 3;
    fin = plan_seq(e);
    r = e + PU + 2 + S + PU + 4;
    abort_at(r);
    e2 = r + 4;
    fin = plan_seq(e2);
    a = fin + 2;
    abort_at(a);
    wait_until(e - 1);
    start = 1'b1;
    wait_until(r);
    rst = 1'b1;
    ctl_reset();
    #1 check_now("async_reset_immediate", RESET_V);
    wait_until(r + 3);
    rst = 1'b0;
    wait_until(a - 1);
    start = 1'b0;
    wait_until(a + 3);
    check_drained("async_reset");

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) k[j] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TO);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
      scenario("random", k[0], k[1], k[2], k[3], ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sdram_startup_sequencer.md
Name: sdram_startup_sequencer

Overview:
- Parametrised successor to the single-channel SDRAM power-up delay.
- Sequences NUM_CH SDRAM channels one after another. Each channel gets:
  - a power-up hold (init_n low),
  - an init-release phase with an acknowledge handshake from its controller and a timeout/retry,
  - a settle delay, then ready.
- Sits between board reset/PLL-lock logic (drives start) and the per-channel SDRAM controllers (consume sdram_init_n, return init_done).

Parameters:
- CLK, 111857000.0, clock frequency in Hz (real).
- NUM_CH, 2, number of SDRAM channels (≥1).
- PU_SEC, 0.201, power-up hold in seconds. PU_CYCLES = $ceil(PU_SEC*CLK), which must be ≥1.
- SETTLE_CYCLES, 64, cycles from init_done to channel ready (≥1).
- TIMEOUT_CYCLES, 4096, max cycles waiting for init_done per attempt (≥1).
- MAX_RETRY, 2, extra power-up attempts per channel after a timeout (≥0).

Ports:
- clk8M  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level. High = run the sequence; low = abort and return to idle.
- init_done  in  NUM_CH  per-channel controller acknowledge (level, sampled on clk8M).
- sdram_init_n  out  NUM_CH  per-channel init request, active low.
- sdram_ready  out  NUM_CH  per-channel ready, sticky until idle.
- all_ready  out  1  all channels ready.
- error  out  1  sequence failed (retries exhausted).
- fail_ch  out  max(1,$clog2(NUM_CH))  index of the failed channel; valid while error=1.

Behaviour:
- All outputs are registered.
- Reset values (async, on rst=1):
  - sdram_init_n = all 1s.
  - sdram_ready = 0, all_ready = 0, error = 0, fail_ch = 0.
  - State = IDLE; internal counter, channel index ch and retry counter all 0.
- Internal counter width = $clog2 of max(PU_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES) + 1.
- States: IDLE, POWERUP, INIT_WAIT, SETTLE, DONE, FAIL.
- Global priority: start=0 sampled in any non-IDLE state → next cycle:
  - state IDLE;
  - all init_n=1, all ready=0, all_ready=0, error=0;
  - counters cleared.
  - start=0 overrides every other transition in the same cycle.
- IDLE:
  - Outputs as reset.
  - start=1 → POWERUP with ch=0, cnt=0, retry=0.
- POWERUP:
  - sdram_init_n[ch]=0; all other init_n bits are 1.
  - Lasts exactly PU_CYCLES cycles: cnt increments; at cnt==PU_CYCLES-1 → INIT_WAIT, cnt=0.
  - init_done is ignored in this state.
- INIT_WAIT:
  - sdram_init_n[ch]=1.
  - init_done[ch]=1 → SETTLE, cnt=0. This has priority over timeout when both occur in the same cycle.
  - Timeout: cnt==TIMEOUT_CYCLES-1 with init_done[ch]=0:
    - retry<MAX_RETRY → retry+1, POWERUP, cnt=0;
    - otherwise → FAIL.
  - init_done bits of other channels are ignored.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles. On the last one, sdram_ready[ch] is set (visible the next cycle).
  - Then: ch==NUM_CH-1 → DONE; otherwise ch+1, retry=0, POWERUP, cnt=0.
- DONE:
  - all_ready=1. Holds while start=1.
  - init_done deasserting afterwards has no effect.
- FAIL:
  - error=1, fail_ch=ch.
  - sdram_ready of earlier channels stays 1; failed and later channels stay 0 with init_n=1.
  - Holds until start=0 or rst.
- Only one channel has init_n low at any time (inrush limiting). Channel k never begins POWERUP before channel k-1 is ready.
- Latency, start rising sampled at edge E:
  - sdram_init_n[0] is low after E and high again after edge E+PU_CYCLES.
  - Total to all_ready with immediate acks ≈ NUM_CH*(PU_CYCLES+1+SETTLE_CYCLES) cycles.
- start re-asserted after an abort restarts from channel 0 with full PU_CYCLES.
- rst mid-sequence: immediate async return to reset values. After release, nothing happens until start is sampled high.

Test Plan:
Bench parameters: CLK=1000.0, PU_SEC=0.01 (PU_CYCLES=10), SETTLE_CYCLES=4, TIMEOUT_CYCLES=8, MAX_RETRY=1, NUM_CH=2.
- Nominal: start=1, controller model raises init_done[ch] 2 cycles after init_n[ch] rises → init_n[0] low for exactly 10 cycles; ready[0] set 4 cycles after ack; then init_n[1] low 10 cycles, ready[1], all_ready=1; error=0 throughout.
- Single timeout: channel 1 ack withheld for the first attempt only → after 8 cycles in INIT_WAIT, init_n[1] low again for 10 cycles; ack on the second attempt → all_ready=1, error=0.
- Exhausted retries: channel 1 never acks → two power-up pulses on init_n[1], then error=1, fail_ch=1, ready=2'b01, all_ready=0; start=0 → next cycle all outputs return to reset values.
- Abort mid-POWERUP: drop start at cycle 5 of channel 0 hold → next cycle init_n=2'b11, ready=0; re-assert start → full 10-cycle hold restarts on channel 0.
- Ack/timeout collision: assert init_done[0] exactly on the cycle cnt==7 in INIT_WAIT → enters SETTLE (no retry pulse), ready[0] set 4 cycles later.
- Async reset: assert rst asynchronously mid-SETTLE of channel 1 → outputs go to reset values without waiting for a clock edge; after release with start=1, sequence restarts at channel 0.
